// File: rtl/datamemory_lsu.sv
// rtl/datamemory_lsu.sv - handshaked load/store unit with byte-lane data RAM
// One access in flight: IDLE accepts, WAIT counts wait states, RESP pulses the result.
module datamemory_lsu #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_fault,
    output logic                  busy
);
    localparam int DEPTH = 2 ** (DM_ADDRESS - 2);

    if (DATA_W != 32) begin : g_bad_width
        $error("datamemory_lsu: DATA_W must be 32");
    end
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("datamemory_lsu: LATENCY must be 0..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [DM_ADDRESS-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    fault_q, fault_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;

    logic [DATA_W-1:0]       mem [DEPTH];
    logic [DM_ADDRESS-3:0]   widx;
    logic [DATA_W-1:0]       word;
    logic [DATA_W-1:0]       word_shift;
    logic [7:0]              load_byte;
    logic [15:0]             load_half;
    logic [DATA_W-1:0]       load_ext;
    logic [3:0]              be;
    logic [DATA_W-1:0]       wlane;
    logic                    mem_we;
    logic                    accept_fault;

    // Misalignment and illegal-funct3 classification of the incoming request.
    always_comb begin
        accept_fault = 1'b1;
        case (req_funct3)
            3'b000:         accept_fault = 1'b0;
            3'b001:         accept_fault = req_addr[0];
            3'b010:         accept_fault = |req_addr[1:0];
            3'b100:         accept_fault = req_we;
            3'b101:         accept_fault = req_we | req_addr[0];
            default:        accept_fault = 1'b1;
        endcase
    end

    assign widx       = addr_q[DM_ADDRESS-1:2];
    assign word       = mem[widx];
    assign word_shift = word >> {addr_q[1:0], 3'b000};
    assign load_byte  = word_shift[7:0];
    assign load_half  = addr_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_ext = '0;
        case (funct3_q)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b010:  load_ext = word;
            3'b100:  load_ext = {24'd0, load_byte};
            3'b101:  load_ext = {16'd0, load_half};
            default: load_ext = '0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be    = 4'b1111;
        wlane = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                wlane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        fault_d  = fault_q;
        rdata_d  = rdata_q;
        mem_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d  = S_WAIT;
                    cnt_d    = 4'(LATENCY);
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    fault_d  = accept_fault;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                    mem_we  = we_q & ~fault_q;
                    rdata_d = (we_q | fault_q) ? '0 : load_ext;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
        end
    end

    // RAM contents survive reset; the write strobe is already dead while state is IDLE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][i*8 +: 8] <= wlane[i*8 +: 8];
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = (state_q == S_RESP) ? rdata_q : '0;
    assign rsp_fault = (state_q == S_RESP) & fault_q;

endmodule

// File: tb/tb_datamemory_lsu.sv
// tb/tb_datamemory_lsu.sv - scoreboard bench for datamemory_lsu at LATENCY 0 and 3
module tb_datamemory_lsu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rv [2];
    logic        rready [2];
    logic        rwe [2];
    logic [2:0]  rf3 [2];
    logic [8:0]  raddr [2];
    logic [31:0] rwd [2];
    logic        rspv [2];
    logic [31:0] rrd [2];
    logic        rspf [2];
    logic        bsy [2];

    datamemory_lsu #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rready[0]),
        .req_we(rwe[0]), .req_funct3(rf3[0]), .req_addr(raddr[0]), .req_wdata(rwd[0]),
        .rsp_valid(rspv[0]), .rsp_rdata(rrd[0]), .rsp_fault(rspf[0]), .busy(bsy[0])
    );

    datamemory_lsu #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rready[1]),
        .req_we(rwe[1]), .req_funct3(rf3[1]), .req_addr(raddr[1]), .req_wdata(rwd[1]),
        .rsp_valid(rspv[1]), .rsp_rdata(rrd[1]), .rsp_fault(rspf[1]), .busy(bsy[1])
    );

    typedef struct {
        int          sel;
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int sel);
        return (sel == 1) ? 3 : 0;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (rspv[k]) begin
                n_vec++;
                assert (sbq.size() != 0 && sbq[0].sel == k) else begin
                    n_err++;
                    $error("FAIL unexpected_rsp dut%0d: observed rsp_valid=1 at cycle %0d, expected no response", k, cyc);
                end
                if (sbq.size() != 0 && sbq[0].sel == k) begin
                    e = sbq.pop_front();
                    n_vec++;
                    assert (rrd[k] === e.rdata) else begin
                        n_err++;
                        $error("FAIL %s rdata: observed %h expected %h", e.tag, rrd[k], e.rdata);
                    end
                    n_vec++;
                    assert (rspf[k] === e.fault) else begin
                        n_err++;
                        $error("FAIL %s fault: observed %b expected %b", e.tag, rspf[k], e.fault);
                    end
                    n_vec++;
                    assert (cyc === e.cyc) else begin
                        n_err++;
                        $error("FAIL %s timing: observed cycle %0d expected cycle %0d", e.tag, cyc, e.cyc);
                    end
                end
            end else begin
                n_vec++;
                assert ({rrd[k], rspf[k]} === 33'd0) else begin
                    n_err++;
                    $error("FAIL idle_outputs dut%0d: observed rdata=%h fault=%b expected 0/0", k, rrd[k], rspf[k]);
                end
            end
        end
    end

    task automatic drive(input int sel, input logic we, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] wd);
        rv[sel]    = 1'b1;
        rwe[sel]   = we;
        rf3[sel]   = f3;
        raddr[sel] = a;
        rwd[sel]   = wd;
    endtask

    task automatic scramble(input int sel);
        rv[sel]    = 1'b0;
        rwe[sel]   = 1'($urandom);
        rf3[sel]   = 3'($urandom);
        raddr[sel] = 9'($urandom);
        rwd[sel]   = $urandom;
    endtask

    task automatic push_exp(input int sel, input logic [31:0] er, input logic ef,
                            input int ecyc, input string tag);
        exp_t e;
        e.sel   = sel;
        e.rdata = er;
        e.fault = ef;
        e.cyc   = ecyc;
        e.tag   = tag;
        sbq.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(posedge clk);
        n_vec++;
        assert (sbq.size() == 0) else begin
            n_err++;
            $error("FAIL %s timeout: observed %0d responses outstanding expected 0", tag, sbq.size());
        end
        sbq.delete();
    endtask

    task automatic issue(input int sel, input logic we, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ef, input string tag);
        @(negedge clk);
        n_vec++;
        assert (rready[sel] === 1'b1 && bsy[sel] === 1'b0) else begin
            n_err++;
            $error("FAIL %s ready_idle: observed ready=%b busy=%b expected 1/0", tag, rready[sel], bsy[sel]);
        end
        drive(sel, we, f3, a, wd);
        push_exp(sel, er, ef, cyc + lat(sel) + 2, tag);
        @(negedge clk);
        scramble(sel);
        drain(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int c0;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rv[k] = 1'b0; rwe[k] = 1'b0; rf3[k] = 3'd0; raddr[k] = 9'd0; rwd[k] = 32'd0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            assert ({rready[k], bsy[k], rspv[k]} === 3'b100) else begin
                n_err++;
                $error("FAIL reset_state dut%0d: observed ready/busy/valid=%b%b%b expected 100", k, rready[k], bsy[k], rspv[k]);
            end
        end

        issue(0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
        issue(0, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10_a");
        issue(0, 1'b1, 3'b000, 9'h011, 32'hAAAAAA7F, 32'h0, 1'b0, "sb_11");
        issue(0, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEAD7FEF, 1'b0, "lw_10_b");
        issue(0, 1'b0, 3'b000, 9'h013, 32'h0, 32'hFFFFFFDE, 1'b0, "lb_13");
        issue(0, 1'b0, 3'b100, 9'h013, 32'h0, 32'h000000DE, 1'b0, "lbu_13");
        issue(0, 1'b0, 3'b000, 9'h011, 32'h0, 32'h0000007F, 1'b0, "lb_11");
        issue(0, 1'b1, 3'b001, 9'h012, 32'h55558001, 32'h0, 1'b0, "sh_12");
        issue(0, 1'b0, 3'b001, 9'h012, 32'h0, 32'hFFFF8001, 1'b0, "lh_12");
        issue(0, 1'b0, 3'b101, 9'h012, 32'h0, 32'h00008001, 1'b0, "lhu_12");
        issue(0, 1'b0, 3'b001, 9'h010, 32'h0, 32'h00007FEF, 1'b0, "lh_10");
        issue(0, 1'b0, 3'b010, 9'h010, 32'h0, 32'h80017FEF, 1'b0, "lw_10_c");
        issue(0, 1'b0, 3'b010, 9'h011, 32'h0, 32'h0, 1'b1, "lw_11_fault");
        issue(0, 1'b1, 3'b001, 9'h013, 32'h0000FFFF, 32'h0, 1'b1, "sh_13_fault");
        issue(0, 1'b0, 3'b011, 9'h010, 32'h0, 32'h0, 1'b1, "ld011_fault");
        issue(0, 1'b1, 3'b100, 9'h010, 32'h11111111, 32'h0, 1'b1, "st100_fault");
        issue(0, 1'b1, 3'b010, 9'h012, 32'h22222222, 32'h0, 1'b1, "sw_12_fault");
        issue(0, 1'b0, 3'b010, 9'h010, 32'h0, 32'h80017FEF, 1'b0, "lw_10_d");

        issue(1, 1'b1, 3'b010, 9'h020, 32'hCAFEF00D, 32'h0, 1'b0, "l3_sw_20");
        issue(1, 1'b0, 3'b010, 9'h020, 32'h0, 32'hCAFEF00D, 1'b0, "l3_lw_20_a");

        @(negedge clk);
        drive(1, 1'b1, 3'b010, 9'h020, 32'h12345678);
        @(negedge clk);
        scramble(1);
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        assert (bsy[1] === 1'b0 && rspv[1] === 1'b0) else begin
            n_err++;
            $error("FAIL reset_midop: observed busy=%b valid=%b expected 0/0", bsy[1], rspv[1]);
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue(1, 1'b0, 3'b010, 9'h020, 32'h0, 32'hCAFEF00D, 1'b0, "l3_lw_after_reset");

        @(negedge clk);
        c0 = cyc;
        push_exp(1, 32'hCAFEF00D, 1'b0, c0 + 5, "l3_hold_1");
        push_exp(1, 32'hCAFEF00D, 1'b0, c0 + 11, "l3_hold_2");
        drive(1, 1'b0, 3'b010, 9'h020, 32'h0);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            n_vec++;
            assert (rready[1] === (j % 6 == 5) && bsy[1] === (j % 6 != 5)) else begin
                n_err++;
                $error("FAIL l3_hold_ready j=%0d: observed ready=%b busy=%b expected ready=%b", j, rready[1], bsy[1], (j % 6 == 5));
            end
        end
        rv[1] = 1'b0;
        drain("l3_hold");
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
